// File: rtl/uds_seq_ctrl_if.sv
// Signal bundle between the UDS job sequencer, its tile source/sink and the datapath.
// The master modport is the sequencer's view; slave is the surrounding environment.
interface uds_seq_ctrl_if #(
    parameter int A  = 64,
    parameter int DW = 32
);
    localparam int IW = A * DW;
    localparam int OW = 2 * (A - 8) * DW;

    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] in_data;

    logic          uds_active;
    logic [IW-1:0] uds_idata;
    logic          uds_idata_valid;
    logic [1:0]    uds_function_mode;
    logic [1:0]    uds_scale_factor;
    logic          uds_odata_valid;
    logic [OW-1:0] uds_odata;

    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_data;
    logic          out_last;

    modport master (
        input  in_valid,
        input  in_data,
        output in_ready,
        output uds_active,
        output uds_idata,
        output uds_idata_valid,
        output uds_function_mode,
        output uds_scale_factor,
        input  uds_odata_valid,
        input  uds_odata,
        output out_valid,
        output out_data,
        output out_last,
        input  out_ready
    );

    modport slave (
        output in_valid,
        output in_data,
        input  in_ready,
        input  uds_active,
        input  uds_idata,
        input  uds_idata_valid,
        input  uds_function_mode,
        input  uds_scale_factor,
        output uds_odata_valid,
        output uds_odata,
        input  out_valid,
        input  out_data,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/uds_seq_ctrl.sv
// Job sequencer in front of the UDS datapath: pulls tiles, times the load/active
// windows, captures one result per tile and streams it out with done/error status.
module uds_seq_ctrl #(
    parameter int A       = 64,
    parameter int DW      = 32,
    parameter int TIMEOUT = 15
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cfg_start_i,
    input  logic [1:0]     cfg_function_mode_i,
    input  logic [1:0]     cfg_scale_factor_i,
    input  logic [15:0]    cfg_tile_count_i,
    output logic           busy_o,
    output logic           done_o,
    output logic           err_cfg_o,
    output logic           err_timeout_o,
    uds_seq_ctrl_if.master bus
);
    localparam int IW = A * DW;
    localparam int OW = 2 * (A - 8) * DW;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_WAIT,
        ST_OUT
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    fm_q, fm_d;
    logic [1:0]    sf_q, sf_d;
    logic [2:0]    run_len_q, run_len_d;
    logic [15:0]   count_q, count_d;
    logic [15:0]   idx_q, idx_d;
    logic [2:0]    run_cnt_q, run_cnt_d;
    logic [TW-1:0] wait_cnt_q, wait_cnt_d;
    logic          strobe_q, strobe_d;
    logic          captured_q, captured_d;
    logic          done_q, done_d;
    logic          err_cfg_q, err_cfg_d;
    logic          err_to_q, err_to_d;
    logic [IW-1:0] idata_q, idata_d;
    logic [OW-1:0] obuf_q, obuf_d;

    logic [2:0]    cfg_run_len;
    logic          cfg_ok;
    logic          is_last;
    logic          in_ready;
    logic          uds_active;
    logic          out_valid;

    // Active-window length per supported mode/scale pair; zero marks unsupported.
    always_comb begin
        cfg_run_len = 3'd0;
        case ({cfg_function_mode_i, cfg_scale_factor_i})
            4'b00_00: cfg_run_len = 3'd2;
            4'b01_00: cfg_run_len = 3'd4;
            4'b00_01: cfg_run_len = 3'd4;
            default:  cfg_run_len = 3'd0;
        endcase
    end

    assign cfg_ok  = (cfg_run_len != 3'd0);
    assign is_last = (idx_q == (count_q - 16'd1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            fm_q       <= 2'd0;
            sf_q       <= 2'd0;
            run_len_q  <= 3'd0;
            count_q    <= 16'd0;
            idx_q      <= 16'd0;
            run_cnt_q  <= 3'd0;
            wait_cnt_q <= '0;
            strobe_q   <= 1'b0;
            captured_q <= 1'b0;
            done_q     <= 1'b0;
            err_cfg_q  <= 1'b0;
            err_to_q   <= 1'b0;
            idata_q    <= '0;
            obuf_q     <= '0;
        end else begin
            state_q    <= state_d;
            fm_q       <= fm_d;
            sf_q       <= sf_d;
            run_len_q  <= run_len_d;
            count_q    <= count_d;
            idx_q      <= idx_d;
            run_cnt_q  <= run_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            strobe_q   <= strobe_d;
            captured_q <= captured_d;
            done_q     <= done_d;
            err_cfg_q  <= err_cfg_d;
            err_to_q   <= err_to_d;
            idata_q    <= idata_d;
            obuf_q     <= obuf_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fm_d       = fm_q;
        sf_d       = sf_q;
        run_len_d  = run_len_q;
        count_d    = count_q;
        idx_d      = idx_q;
        run_cnt_d  = run_cnt_q;
        wait_cnt_d = wait_cnt_q;
        strobe_d   = 1'b0;
        captured_d = captured_q;
        done_d     = 1'b0;
        err_cfg_d  = err_cfg_q;
        err_to_d   = err_to_q;
        idata_d    = idata_q;
        obuf_d     = obuf_q;
        in_ready   = 1'b0;
        uds_active = 1'b0;
        out_valid  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cfg_start_i) begin
                    if (!cfg_ok) begin
                        err_cfg_d = 1'b1;
                        done_d    = 1'b1;
                    end else if (cfg_tile_count_i == 16'd0) begin
                        done_d = 1'b1;
                    end else begin
                        err_cfg_d = 1'b0;
                        err_to_d  = 1'b0;
                        fm_d      = cfg_function_mode_i;
                        sf_d      = cfg_scale_factor_i;
                        run_len_d = cfg_run_len;
                        count_d   = cfg_tile_count_i;
                        idx_d     = 16'd0;
                        state_d   = ST_LOAD;
                    end
                end
            end

            // Second LOAD cycle is the datapath load strobe; no new tile is accepted then.
            ST_LOAD: begin
                if (strobe_q) begin
                    run_cnt_d = 3'd0;
                    state_d   = ST_RUN;
                end else begin
                    in_ready = 1'b1;
                    if (bus.in_valid) begin
                        idata_d    = bus.in_data;
                        strobe_d   = 1'b1;
                        captured_d = 1'b0;
                    end
                end
            end

            ST_RUN: begin
                uds_active = 1'b1;
                if (bus.uds_odata_valid && !captured_q) begin
                    obuf_d     = bus.uds_odata;
                    captured_d = 1'b1;
                end
                if (run_cnt_q == (run_len_q - 3'd1)) begin
                    wait_cnt_d = '0;
                    state_d    = ST_WAIT;
                end else begin
                    run_cnt_d = run_cnt_q + 3'd1;
                end
            end

            ST_WAIT: begin
                if (captured_q) begin
                    state_d = ST_OUT;
                end else if (bus.uds_odata_valid) begin
                    obuf_d     = bus.uds_odata;
                    captured_d = 1'b1;
                    state_d    = ST_OUT;
                end else if (wait_cnt_q == TW'(TIMEOUT - 1)) begin
                    err_to_d = 1'b1;
                    done_d   = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end

            ST_OUT: begin
                out_valid = 1'b1;
                if (bus.out_ready) begin
                    if (is_last) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + 16'd1;
                        state_d = ST_LOAD;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign busy_o        = (state_q != ST_IDLE);
    assign done_o        = done_q;
    assign err_cfg_o     = err_cfg_q;
    assign err_timeout_o = err_to_q;

    assign bus.in_ready          = in_ready;
    assign bus.uds_active        = uds_active;
    assign bus.uds_idata         = idata_q;
    assign bus.uds_idata_valid   = strobe_q;
    assign bus.uds_function_mode = fm_q;
    assign bus.uds_scale_factor  = sf_q;
    assign bus.out_valid         = out_valid;
    assign bus.out_data          = obuf_q;
    assign bus.out_last          = out_valid & is_last;
endmodule

// File: doc/uds_seq_ctrl.md
Name: uds_seq_ctrl

Overview:
- Job sequencer placed in front of the up/down-sampling (UDS) datapath.
- Accepts a job config (mode, scale factor, tile count) and pulls input tiles over a valid/ready stream.
- Drives each tile into the datapath with the required load/active timing, captures the datapath result, and returns it on a valid/ready output stream.
- Reports job completion and timeout errors.

Parameters:
A, 64, elements per input tile (8 x 8)
DW, 32, bits per element
TIMEOUT, 15, max cycles to wait for datapath result after RUN ends

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cfg_start  in  1  start job pulse; sampled only in IDLE
cfg_function_mode  in  2  datapath function mode for job
cfg_scale_factor  in  2  datapath scale factor for job
cfg_tile_count  in  16  tiles in job; 0 = no-op job
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at job end (normal, abort or reject)
err_cfg  out  1  sticky: unsupported mode/scale combination
err_timeout  out  1  sticky: datapath result missing
in_valid  in  1  input tile valid
in_ready  out  1  input tile accepted when in_valid & in_ready
in_data  in  A*DW  input tile
uds_active  out  1  datapath active
uds_idata  out  A*DW  tile to datapath
uds_idata_valid  out  1  datapath load strobe
uds_function_mode  out  2  latched mode
uds_scale_factor  out  2  latched scale factor
uds_odata_valid  in  1  datapath result strobe
uds_odata  in  2*(A-8)*DW  datapath result
out_valid  out  1  result valid
out_ready  in  1  result consumed when out_valid & out_ready
out_data  out  2*(A-8)*DW  result
out_last  out  1  high with last tile's result

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, output buffer empty. Reset mid-job abandons the job silently (no done pulse).
- Config latched on accepted cfg_start; uds_function_mode and uds_scale_factor are driven from the latched copy and stay stable for the whole job. cfg_* changes during busy are ignored, and cfg_start while busy is ignored.
- RUN_LEN per latched config:
  - fm=00, sf=0: 2
  - fm=01, sf=0: 4
  - fm=00, sf=1: 4
  - any other combination is unsupported.
- FSM states: IDLE, LOAD, RUN, WAIT, OUT.
- IDLE:
  - cfg_start with supported config and count > 0: clear both err flags, busy=1, go to LOAD.
  - Unsupported config: set err_cfg, pulse done next cycle, stay IDLE, busy stays 0.
  - count = 0: pulse done, stay IDLE.
- LOAD:
  - in_ready=1, uds_active=0.
  - On in_valid handshake: register in_data to uds_idata and pulse uds_idata_valid for exactly one cycle (the cycle after the handshake), then go to RUN.
  - Waits indefinitely for in_valid.
- RUN: uds_active=1 for exactly RUN_LEN consecutive cycles, then go to WAIT with uds_active=0.
- Result capture:
  - uds_odata_valid is accepted in RUN or WAIT.
  - First occurrence captures uds_odata into the output buffer; later strobes for the same tile are ignored.
  - Capture in RUN finishes RUN_LEN first, then passes through WAIT for one cycle to OUT.
- WAIT:
  - Captured result: go to OUT.
  - Otherwise count cycles. After TIMEOUT cycles without a result: set err_timeout, drop remaining tiles, pulse done, go to IDLE with busy=0.
- OUT:
  - out_valid=1 holding the buffer; out_last=1 when tile index = count-1.
  - On out_ready: advance the index. Last tile: pulse done, busy=0, go to IDLE. Otherwise go to LOAD.
  - out_data and out_valid stay stable while stalled.
- Tile gap: uds_active is low for at least 2 cycles between consecutive tiles (the LOAD handshake cycle plus the strobe cycle).
- Tile index is 16-bit; count 65535 must complete without wrap.
- in_ready is never high outside LOAD. out_valid is never high outside OUT.
- Total latency per tile with no stalls: 1 (handshake) + 1 (strobe) + RUN_LEN + WAIT cycles + 1 (output).

Test Plan:
- fm=00, sf=0, count=3, in_valid held high, datapath model returns 1 cycle after RUN, out_ready=1 -> 3 outputs in order; out_last on the 3rd only; uds_active high for 2 cycles per tile; one done pulse; err flags 0.
- fm=01, sf=0, count=2, out_ready low for 5 cycles on tile 0 -> out_data stable while stalled; no second in_ready until handshake; uds_active high for 4 cycles per tile.
- fm=10, sf=1 start -> err_cfg=1, done pulses once, busy never rises, no in_ready.
- fm=00, sf=1, count=4, model withholds uds_odata_valid for tile 1 -> err_timeout set 15 cycles after RUN ends; done pulse; tiles 2-3 never requested; next valid start clears err_timeout.
- cfg_start again mid-job and cfg_function_mode toggled mid-job -> ignored; uds_function_mode unchanged; count=0 start -> done only.
- rst_n asserted during RUN of tile 1 of 3 -> all outputs 0 immediately; no done; new job after release runs normally.
